// File: rtl/program_loader_if.sv
// Host FIFO read port and memory write ports of the program loader.
// master: loader side; slave: FIFO/memory side.
interface program_loader_if #(
  parameter int WORD_W         = 32,
  parameter int NU_COUNT       = 8,
  parameter int INST_MEM_DEPTH = 8,
  parameter int INST_MEM_SIZE  = 32,
  parameter int W_MEM_DEPTH    = 10,
  parameter int XY_MEM_DEPTH   = 10,
  parameter int DATA_W         = 16
);
  logic                      load_enable;
  logic                      buffer_empty;
  logic [WORD_W-1:0]         buffer_data;
  logic                      buffer_read_enable;
  logic                      inst_write_enable;
  logic [INST_MEM_DEPTH-1:0] inst_write_addr;
  logic [INST_MEM_SIZE-1:0]  inst_write_data;
  logic [NU_COUNT-1:0]       w_write_enable;
  logic [W_MEM_DEPTH-1:0]    w_write_addr;
  logic                      mm_xy_write_enable;
  logic [XY_MEM_DEPTH-1:0]   mm_write_addr;
  logic [DATA_W-1:0]         mm_write_data;
  logic                      busy;
  logic                      done;
  logic                      error;

  modport master (
    input  load_enable, buffer_empty, buffer_data,
    output buffer_read_enable,
    output inst_write_enable, inst_write_addr, inst_write_data,
    output w_write_enable, w_write_addr,
    output mm_xy_write_enable, mm_write_addr, mm_write_data,
    output busy, done, error
  );

  modport slave (
    output load_enable, buffer_empty, buffer_data,
    input  buffer_read_enable,
    input  inst_write_enable, inst_write_addr, inst_write_data,
    input  w_write_enable, w_write_addr,
    input  mm_xy_write_enable, mm_write_addr, mm_write_data,
    input  busy, done, error
  );
endinterface

// File: rtl/program_loader.sv
// Pops header/payload words from the host FIFO and writes instruction,
// weight and XY memories. Ports: clk, reset_n, bus (program_loader_if.master).
module program_loader #(
  parameter int WORD_W         = 32,
  parameter int NU_COUNT       = 8,
  parameter int INST_MEM_DEPTH = 8,
  parameter int INST_MEM_SIZE  = 32,
  parameter int W_MEM_DEPTH    = 10,
  parameter int XY_MEM_DEPTH   = 10,
  parameter int DATA_W         = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  program_loader_if.master  bus
);
  localparam int AW0 = (INST_MEM_DEPTH > W_MEM_DEPTH) ?
                       INST_MEM_DEPTH : W_MEM_DEPTH;
  localparam int AW  = (AW0 > XY_MEM_DEPTH) ? AW0 : XY_MEM_DEPTH;

  typedef enum logic [0:0] {S_HEADER, S_PAYLOAD} state_t;
  typedef enum logic [1:0] {
    T_INST, T_WEIGHT, T_XY, T_END
  } tgt_t;

  state_t              state_q, state_d;
  tgt_t                tgt_q, tgt_d;
  logic [5:0]          nu_q, nu_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [11:0]         rem_q, rem_d;
  logic                iwe_q, iwe_d;
  logic [NU_COUNT-1:0] wwe_q, wwe_d;
  logic                xwe_q, xwe_d;
  logic [AW-1:0]       waddr_q, waddr_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic       pop;
  tgt_t       h_tgt;
  logic [5:0] h_nu;
  logic [11:0] h_base;
  logic [11:0] h_cnt;
  logic       nu_bad;

  assign h_tgt  = tgt_t'(bus.buffer_data[WORD_W-1 -: 2]);
  assign h_nu   = bus.buffer_data[WORD_W-3 -: 6];
  assign h_base = bus.buffer_data[WORD_W-9 -: 12];
  assign h_cnt  = bus.buffer_data[WORD_W-21 -: 12];
  assign nu_bad = 32'(nu_q) >= NU_COUNT;

  // Gated by reset so no word is lost while the loader is held.
  assign pop = bus.load_enable & ~bus.buffer_empty & reset_n;

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    nu_d    = nu_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    iwe_d   = 1'b0;
    wwe_d   = '0;
    xwe_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      S_HEADER: begin
        if (pop) begin
          tgt_d = h_tgt;
          nu_d  = h_nu;
          if (h_tgt == T_WEIGHT && 32'(h_nu) >= NU_COUNT)
            err_d = 1'b1;
          if (h_tgt == T_END) begin
            done_d = 1'b1;
          end else if (h_cnt != 12'd0) begin
            state_d = S_PAYLOAD;
            addr_d  = h_base[AW-1:0];
            rem_d   = h_cnt;
          end
        end
      end
      S_PAYLOAD: begin
        if (pop) begin
          waddr_d = addr_q;
          wdata_d = bus.buffer_data;
          unique case (1'b1)
            tgt_q == T_INST:   iwe_d = 1'b1;
            tgt_q == T_WEIGHT:
              if (!nu_bad) wwe_d = NU_COUNT'(1) << nu_q;
            tgt_q == T_XY:     xwe_d = 1'b1;
            default: ;
          endcase
          // Counter wraps mod 2^AW, a multiple of every memory depth.
          addr_d = addr_q + 1'b1;
          rem_d  = rem_q - 12'd1;
          if (rem_q == 12'd1) state_d = S_HEADER;
        end
      end
      default: state_d = S_HEADER;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_HEADER;
      tgt_q   <= T_INST;
      nu_q    <= '0;
      addr_q  <= '0;
      rem_q   <= '0;
      iwe_q   <= 1'b0;
      wwe_q   <= '0;
      xwe_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      nu_q    <= nu_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      iwe_q   <= iwe_d;
      wwe_q   <= wwe_d;
      xwe_q   <= xwe_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.buffer_read_enable = pop;
  assign bus.inst_write_enable  = iwe_q;
  assign bus.inst_write_addr    = waddr_q[INST_MEM_DEPTH-1:0];
  assign bus.inst_write_data    = wdata_q[INST_MEM_SIZE-1:0];
  assign bus.w_write_enable     = wwe_q;
  assign bus.w_write_addr       = waddr_q[W_MEM_DEPTH-1:0];
  assign bus.mm_xy_write_enable = xwe_q;
  assign bus.mm_write_addr      = waddr_q[XY_MEM_DEPTH-1:0];
  assign bus.mm_write_data      = wdata_q[DATA_W-1:0];
  assign bus.busy               = (state_q == S_PAYLOAD);
  assign bus.done               = done_q;
  assign bus.error              = err_q;
endmodule

// File: tb/tb_program_loader.sv
// Directed vector bench for program_loader.
// Drives the FIFO side of the interface and checks memory writes.
module tb_program_loader;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  program_loader_if bus ();

  program_loader dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        le;
    logic        emp;
    logic [31:0] data;
    logic        rd;
    logic        iwe;
    logic [7:0]  wwe;
    logic        xwe;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
  } vec_t;

  vec_t vq[$];

  function automatic logic [31:0] hdr(
    logic [1:0] t, logic [5:0] n,
    logic [11:0] b, logic [11:0] c);
    return {t, n, b, c};
  endfunction

  function automatic vec_t mk(
    logic le, logic emp, logic [31:0] data,
    logic rd, logic iwe, logic [7:0] wwe,
    logic xwe, logic [11:0] addr,
    logic [31:0] wdata, logic busy,
    logic done, logic err);
    vec_t v;
    v.le = le; v.emp = emp; v.data = data;
    v.rd = rd; v.iwe = iwe; v.wwe = wwe;
    v.xwe = xwe; v.addr = addr;
    v.wdata = wdata; v.busy = busy;
    v.done = done; v.err = err;
    return v;
  endfunction

  function automatic void add(
    logic le, logic emp, logic [31:0] data,
    logic rd, logic iwe, logic [7:0] wwe,
    logic xwe, logic [11:0] addr,
    logic [31:0] wdata, logic busy,
    logic done, logic err);
    vq.push_back(mk(le, emp, data, rd, iwe, wwe,
                    xwe, addr, wdata, busy, done, err));
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".rd"},   32'(bus.buffer_read_enable), 0);
    chk({tag, ".iwe"},  32'(bus.inst_write_enable), 0);
    chk({tag, ".wwe"},  32'(bus.w_write_enable), 0);
    chk({tag, ".xwe"},  32'(bus.mm_xy_write_enable), 0);
    chk({tag, ".addr"}, 32'(bus.mm_write_addr), 0);
    chk({tag, ".data"}, 32'(bus.inst_write_data), 0);
    chk({tag, ".busy"}, 32'(bus.busy), 0);
    chk({tag, ".done"}, 32'(bus.done), 0);
    chk({tag, ".err"},  32'(bus.error), 0);
  endtask

  task automatic step(input vec_t v, input string tag);
    @(negedge clk);
    bus.load_enable  = v.le;
    bus.buffer_empty = v.emp;
    bus.buffer_data  = v.data;
    #1;
    chk({tag, ".rd"}, 32'(bus.buffer_read_enable), 32'(v.rd));
    @(posedge clk);
    #1;
    chk({tag, ".iwe"},  32'(bus.inst_write_enable), 32'(v.iwe));
    chk({tag, ".wwe"},  32'(bus.w_write_enable), 32'(v.wwe));
    chk({tag, ".xwe"},  32'(bus.mm_xy_write_enable), 32'(v.xwe));
    chk({tag, ".busy"}, 32'(bus.busy), 32'(v.busy));
    chk({tag, ".done"}, 32'(bus.done), 32'(v.done));
    chk({tag, ".err"},  32'(bus.error), 32'(v.err));
    if (v.iwe) begin
      chk({tag, ".iaddr"}, 32'(bus.inst_write_addr), 32'(v.addr[7:0]));
      chk({tag, ".idata"}, 32'(bus.inst_write_data), v.wdata);
    end
    if (v.wwe != 8'h00) begin
      chk({tag, ".waddr"}, 32'(bus.w_write_addr), 32'(v.addr[9:0]));
      chk({tag, ".maddr"}, 32'(bus.mm_write_addr), 32'(v.addr[9:0]));
      chk({tag, ".wdata"}, 32'(bus.mm_write_data), 32'(v.wdata[15:0]));
    end
    if (v.xwe) begin
      chk({tag, ".xaddr"}, 32'(bus.mm_write_addr), 32'(v.addr[9:0]));
      chk({tag, ".xdata"}, 32'(bus.mm_write_data), 32'(v.wdata[15:0]));
    end
  endtask

  localparam logic [31:0] IDLE = 32'hFFFF_FFFF;

  initial begin
    bus.load_enable  = 1'b0;
    bus.buffer_empty = 1'b1;
    bus.buffer_data  = '0;

    // INST base 4 count 3, back-to-back
    add(1,0,hdr(2'd0,6'd0,12'h004,12'd3),1,0,8'h00,0,12'h000,0,1,0,0);
    add(1,0,32'hA5A5_0001,1,1,8'h00,0,12'h004,32'hA5A5_0001,1,0,0);
    add(1,0,32'hA5A5_0002,1,1,8'h00,0,12'h005,32'hA5A5_0002,1,0,0);
    add(1,0,32'hA5A5_0003,1,1,8'h00,0,12'h006,32'hA5A5_0003,0,0,0);
    // WEIGHT nu 2 base 0x3FE count 4, address wrap
    add(1,0,hdr(2'd1,6'd2,12'h3FE,12'd4),1,0,8'h00,0,12'h000,0,1,0,0);
    add(1,0,32'h0000_1111,1,0,8'h04,0,12'h3FE,32'h1111,1,0,0);
    add(1,0,32'h0000_2222,1,0,8'h04,0,12'h3FF,32'h2222,1,0,0);
    add(1,0,32'h0000_3333,1,0,8'h04,0,12'h000,32'h3333,1,0,0);
    add(1,0,32'h0000_4444,1,0,8'h04,0,12'h001,32'h4444,0,0,0);
    // XY count 2 with 5 empty cycles and a load_enable stall
    add(1,0,hdr(2'd2,6'd0,12'h010,12'd2),1,0,8'h00,0,12'h000,0,1,0,0);
    add(1,0,32'h0000_00AB,1,0,8'h00,1,12'h010,32'h00AB,1,0,0);
    for (int i = 0; i < 5; i++)
      add(1,1,IDLE,0,0,8'h00,0,12'h000,0,1,0,0);
    add(0,0,32'h0000_00CD,0,0,8'h00,0,12'h000,0,1,0,0);
    add(1,0,32'h0000_00CD,1,0,8'h00,1,12'h011,32'h00CD,0,0,0);
    // count 0 header, idle, END -> done pulse
    add(1,0,hdr(2'd0,6'd0,12'h000,12'd0),1,0,8'h00,0,12'h000,0,0,0,0);
    add(0,1,IDLE,0,0,8'h00,0,12'h000,0,0,0,0);
    add(1,0,hdr(2'd3,6'd0,12'h000,12'd0),1,0,8'h00,0,12'h000,0,0,1,0);
    add(1,1,IDLE,0,0,8'h00,0,12'h000,0,0,0,0);
    // bad NU select: dropped payload, sticky error, XY still written
    add(1,0,hdr(2'd1,6'd9,12'h000,12'd2),1,0,8'h00,0,12'h000,0,1,0,1);
    add(1,0,32'h0000_5555,1,0,8'h00,0,12'h000,0,1,0,1);
    add(1,0,32'h0000_6666,1,0,8'h00,0,12'h000,0,0,0,1);
    add(1,0,hdr(2'd2,6'd0,12'h020,12'd1),1,0,8'h00,0,12'h000,0,1,0,1);
    add(1,0,32'h0000_0077,1,0,8'h00,1,12'h020,32'h0077,0,0,1);

    repeat (3) @(posedge clk);
    #1;
    chk_zero("rst");
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vq[i]) step(vq[i], $sformatf("v%0d", i));

    // Reset mid-payload after 2 of 5 words
    step(mk(1,0,hdr(2'd2,6'd0,12'h100,12'd5),1,0,8'h00,0,
            12'h000,0,1,0,1), "r0");
    step(mk(1,0,32'h0000_0101,1,0,8'h00,1,12'h100,32'h0101,1,0,1), "r1");
    step(mk(1,0,32'h0000_0202,1,0,8'h00,1,12'h101,32'h0202,1,0,1), "r2");
    #2;
    reset_n = 1'b0;
    #1;
    chk_zero("mid");
    @(negedge clk);
    bus.load_enable = 1'b0;
    reset_n = 1'b1;
    step(mk(1,0,hdr(2'd0,6'd0,12'h007,12'd1),1,0,8'h00,0,
            12'h000,0,1,0,0), "p0");
    step(mk(1,0,32'hDEAD_BEEF,1,1,8'h00,0,12'h007,32'hDEAD_BEEF,0,0,0), "p1");
    step(mk(1,1,IDLE,0,0,8'h00,0,12'h000,0,0,0,0), "p2");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
